voxel_ray_marcher: RTL and testbench



---
 rtl/voxel_ray_marcher_pkg.sv | 45 ++++
 rtl/voxel_ray_marcher_dda_axis_select.sv | 22 ++
 rtl/voxel_ray_marcher.sv | 182 ++++++++++++++++++
 tb/tb_voxel_ray_marcher.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_ray_marcher_pkg.sv
// Shared block, position and face types for the voxel ray marcher and the
// chunk lookup interface it drives.
package voxel_ray_marcher_pkg;

    localparam int CHUNK_WIDTH = 40;
    localparam int COORD_WIDTH = 7;
    localparam int TVEC_WIDTH  = 16;
    localparam int CHUNK_MIN   = -CHUNK_WIDTH;
    localparam int CHUNK_MAX   = CHUNK_WIDTH - 1;

    typedef enum logic [7:0] {
        BLOCK_AIR   = 8'd0,
        BLOCK_STONE = 8'd1,
        BLOCK_DIRT  = 8'd2,
        BLOCK_GRASS = 8'd3,
        BLOCK_WATER = 8'd4
    } BlockType;

    typedef struct packed {
        logic signed [COORD_WIDTH-1:0] z;
        logic signed [COORD_WIDTH-1:0] y;
        logic signed [COORD_WIDTH-1:0] x;
    } BlockPos;

    typedef enum logic [2:0] {
        FACE_NONE  = 3'd0,
        FACE_POS_X = 3'd1,
        FACE_NEG_X = 3'd2,
        FACE_POS_Y = 3'd3,
        FACE_NEG_Y = 3'd4,
        FACE_POS_Z = 3'd5,
        FACE_NEG_Z = 3'd6
    } BlockFace;

    typedef struct packed {
        logic [TVEC_WIDTH-1:0] z;
        logic [TVEC_WIDTH-1:0] y;
        logic [TVEC_WIDTH-1:0] x;
    } TVec;

    function automatic logic in_chunk(input logic signed [COORD_WIDTH:0] c);
        return (int'(c) >= CHUNK_MIN) && (int'(c) <= CHUNK_MAX);
    endfunction

endpackage

// File: rtl/voxel_ray_marcher_dda_axis_select.sv
// Picks the DDA axis with the smallest t_max; ties resolve x, then y, then z.
module dda_axis_select #(
    parameter int T_WIDTH = 16
) (
    input  logic [T_WIDTH-1:0] t_x,
    input  logic [T_WIDTH-1:0] t_y,
    input  logic [T_WIDTH-1:0] t_z,
    output logic [2:0]         axis_onehot
);

    always_comb begin
        axis_onehot = 3'b000;
        if ((t_x <= t_y) && (t_x <= t_z)) begin
            axis_onehot = 3'b001;
        end else if (t_y <= t_z) begin
            axis_onehot = 3'b010;
        end else begin
            axis_onehot = 3'b100;
        end
    end

endmodule

// File: rtl/voxel_ray_marcher.sv
// Voxel ray marcher: integer 3D DDA that queries the chunk voxel by voxel.
// States: IDLE wait start | QUERY hold lookup | STEP advance one voxel | DONE result pulse
module voxel_ray_marcher
    import voxel_ray_marcher_pkg::*;
#(
    parameter int T_WIDTH    = TVEC_WIDTH,
    parameter int MAX_STEPS  = 64,
    parameter int STEP_WIDTH = 7
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start,
    input  BlockPos                 origin,
    input  logic [2:0]              step_neg,
    input  logic [3*T_WIDTH-1:0]    t_max_init,
    input  logic [3*T_WIDTH-1:0]    t_delta,
    output logic                    busy,
    output logic                    done,
    output logic                    hit,
    output BlockPos                 hit_pos,
    output BlockType                hit_block,
    output BlockFace                hit_face,
    output logic [STEP_WIDTH-1:0]   steps,
    output BlockPos                 query_addr,
    output logic                    query_read_enable,
    input  BlockType                query_block,
    input  logic                    query_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_QUERY, ST_STEP, ST_DONE} state_e;

    localparam logic signed [COORD_WIDTH:0] ONE = {{COORD_WIDTH{1'b0}}, 1'b1};

    state_e state_q, state_d;

    logic signed [COORD_WIDTH-1:0] pos_q     [3];
    logic [T_WIDTH-1:0]            t_max_q   [3];
    logic [T_WIDTH-1:0]            t_delta_q [3];
    logic [2:0]                    step_neg_q;

    logic [2:0]                    axis_sel;
    logic signed [COORD_WIDTH:0]   pos_next  [3];
    logic [T_WIDTH:0]              t_sum     [3];
    logic [T_WIDTH-1:0]            t_next    [3];
    logic                          out_of_chunk;
    logic [STEP_WIDTH-1:0]         steps_inc;
    logic                          step_limit;
    BlockFace                      step_face;

    dda_axis_select #(.T_WIDTH(T_WIDTH)) u_axis_select (
        .t_x         (t_max_q[0]),
        .t_y         (t_max_q[1]),
        .t_z         (t_max_q[2]),
        .axis_onehot (axis_sel)
    );

    assign query_addr = {pos_q[2], pos_q[1], pos_q[0]};
    assign steps_inc  = steps + 1'b1;
    assign step_limit = (steps_inc == STEP_WIDTH'(MAX_STEPS));

    // Coordinates are widened by one bit so the bounds check sees the true value.
    always_comb begin
        out_of_chunk = 1'b0;
        for (int a = 0; a < 3; a++) begin
            pos_next[a] = {pos_q[a][COORD_WIDTH-1], pos_q[a]};
            if (axis_sel[a]) begin
                pos_next[a] = step_neg_q[a] ? (pos_next[a] - ONE) : (pos_next[a] + ONE);
            end
            t_sum[a]  = {1'b0, t_max_q[a]} + {1'b0, t_delta_q[a]};
            t_next[a] = t_sum[a][T_WIDTH] ? '1 : t_sum[a][T_WIDTH-1:0];
            if (!in_chunk(pos_next[a])) begin
                out_of_chunk = 1'b1;
            end
        end
    end

    always_comb begin
        step_face = FACE_NONE;
        if (axis_sel[0]) begin
            step_face = step_neg_q[0] ? FACE_POS_X : FACE_NEG_X;
        end else if (axis_sel[1]) begin
            step_face = step_neg_q[1] ? FACE_POS_Y : FACE_NEG_Y;
        end else if (axis_sel[2]) begin
            step_face = step_neg_q[2] ? FACE_POS_Z : FACE_NEG_Z;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        busy              = 1'b0;
        done              = 1'b0;
        query_read_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                busy              = 1'b1;
                query_read_enable = 1'b1;
                if (query_valid) begin
                    state_d = (query_block != BLOCK_AIR) ? ST_DONE : ST_STEP;
                end
            end
            ST_STEP: begin
                busy    = 1'b1;
                state_d = (out_of_chunk || step_limit) ? ST_DONE : ST_QUERY;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int a = 0; a < 3; a++) begin
                pos_q[a]     <= '0;
                t_max_q[a]   <= '0;
                t_delta_q[a] <= '0;
            end
            step_neg_q <= '0;
            steps      <= '0;
            hit        <= 1'b0;
            hit_pos    <= '0;
            hit_block  <= BLOCK_AIR;
            hit_face   <= FACE_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pos_q[0] <= origin.x;
                        pos_q[1] <= origin.y;
                        pos_q[2] <= origin.z;
                        for (int a = 0; a < 3; a++) begin
                            t_max_q[a]   <= t_max_init[a*T_WIDTH +: T_WIDTH];
                            t_delta_q[a] <= t_delta[a*T_WIDTH +: T_WIDTH];
                        end
                        step_neg_q <= step_neg;
                        steps      <= '0;
                        hit        <= 1'b0;
                        hit_block  <= BLOCK_AIR;
                        hit_face   <= FACE_NONE;
                    end
                end
                ST_QUERY: begin
                    if (query_valid) begin
                        hit_pos   <= query_addr;
                        hit_block <= query_block;
                        hit       <= (query_block != BLOCK_AIR);
                    end
                end
                ST_STEP: begin
                    steps    <= steps_inc;
                    hit_face <= step_face;
                    // An out-of-chunk step is never queried, so pos keeps the last voxel.
                    if (!out_of_chunk) begin
                        for (int a = 0; a < 3; a++) begin
                            pos_q[a] <= pos_next[a][COORD_WIDTH-1:0];
                            if (axis_sel[a]) begin
                                t_max_q[a] <= t_next[a];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_ray_marcher.sv
// Randomized bench for voxel_ray_marcher with a chunk responder and a reference ray walk.
module tb_voxel_ray_marcher;
    import voxel_ray_marcher_pkg::*;

    localparam int TW   = 16;
    localparam int MAXS = 4;
    localparam int SW   = 7;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              start  = 1'b0;
    BlockPos           origin = '0;
    logic [2:0]        step_neg = '0;
    logic [3*TW-1:0]   t_max_init = '0;
    logic [3*TW-1:0]   t_delta = '0;
    logic              busy, done, hit;
    BlockPos           hit_pos;
    BlockType          hit_block;
    BlockFace          hit_face;
    logic [SW-1:0]     steps;
    BlockPos           query_addr;
    logic              query_read_enable;
    BlockType          query_block = BLOCK_AIR;
    logic              query_valid = 1'b0;

    always #5 clk_in = ~clk_in;

    voxel_ray_marcher #(.T_WIDTH(TW), .MAX_STEPS(MAXS), .STEP_WIDTH(SW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .start             (start),
        .origin            (origin),
        .step_neg          (step_neg),
        .t_max_init        (t_max_init),
        .t_delta           (t_delta),
        .busy              (busy),
        .done              (done),
        .hit               (hit),
        .hit_pos           (hit_pos),
        .hit_block         (hit_block),
        .hit_face          (hit_face),
        .steps             (steps),
        .query_addr        (query_addr),
        .query_read_enable (query_read_enable),
        .query_block       (query_block),
        .query_valid       (query_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    BlockType world [int];

    function automatic int pkey(input int x, input int y, input int z);
        return ((x + 64) << 14) | ((y + 64) << 7) | (z + 64);
    endfunction

    function automatic BlockType world_at(input int x, input int y, input int z);
        if (world.exists(pkey(x, y, z))) return world[pkey(x, y, z)];
        return BLOCK_AIR;
    endfunction

    function automatic int addr_key(input BlockPos p);
        return pkey(32'(p.x), 32'(p.y), 32'(p.z));
    endfunction

    // Chunk responder: answers each lookup resp_lat cycles after it first appears.
    int cyc_cnt = 0;
    int done_cnt = 0;
    int resp_lat = 2;
    int wait_cnt = 0;
    int addr_changes = 0;
    int last_valid_cyc = 0;
    int got_q [$];
    BlockPos held_addr = '0;

    always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk_in) if (done === 1'b1) done_cnt++;

    always begin
        @(posedge clk_in);
        #1;
        query_valid = 1'b0;
        query_block = BLOCK_AIR;
        if (rst_in || query_read_enable !== 1'b1) begin
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) begin
                held_addr = query_addr;
                got_q.push_back(addr_key(query_addr));
            end else if (query_addr !== held_addr) begin
                addr_changes++;
            end
            if (wait_cnt == resp_lat) begin
                query_valid    = 1'b1;
                query_block    = world_at(32'(query_addr.x), 32'(query_addr.y), 32'(query_addr.z));
                last_valid_cyc = cyc_cnt;
            end
            wait_cnt++;
        end
    end

    // Reference walk: plain integer DDA over the world map.
    int       m_o [3];
    int       m_tm [3];
    int       m_td [3];
    logic [2:0] m_neg;
    int       e_hit, e_steps;
    int       e_pos [3];
    BlockType e_block;
    BlockFace e_face;
    int       exp_q [$];

    function automatic BlockFace face_of(input int axis, input logic neg);
        case (axis)
            0:       return neg ? FACE_POS_X : FACE_NEG_X;
            1:       return neg ? FACE_POS_Y : FACE_NEG_Y;
            default: return neg ? FACE_POS_Z : FACE_NEG_Z;
        endcase
    endfunction

    task automatic model_march();
        int p [3];
        int tm [3];
        int a;
        int sum;
        bit fin;
        BlockType b;
        exp_q.delete();
        p = m_o;
        tm = m_tm;
        e_hit = 0; e_steps = 0; e_block = BLOCK_AIR; e_face = FACE_NONE;
        fin = 0;
        for (int it = 0; it <= MAXS && !fin; it++) begin
            exp_q.push_back(pkey(p[0], p[1], p[2]));
            e_pos = p;
            b = world_at(p[0], p[1], p[2]);
            if (b != BLOCK_AIR) begin
                e_hit = 1;
                e_block = b;
                fin = 1;
            end else begin
                a = 0;
                if (tm[1] < tm[a]) a = 1;
                if (tm[2] < tm[a]) a = 2;
                p[a] = p[a] + (m_neg[a] ? -1 : 1);
                sum = tm[a] + m_td[a];
                tm[a] = (sum > 65535) ? 65535 : sum;
                e_steps++;
                e_face = face_of(a, m_neg[a]);
                if (p[a] < -CHUNK_WIDTH || p[a] >= CHUNK_WIDTH || e_steps == MAXS) fin = 1;
            end
        end
    endtask

    task automatic run_march(input string tag, input int ox, input int oy, input int oz,
                             input logic [2:0] neg, input int tx, input int ty, input int tz,
                             input int dx, input int dy, input int dz, input int lat);
        TVec tv;
        int  cyc, d0, mism;
        m_o[0] = ox; m_o[1] = oy; m_o[2] = oz;
        m_tm[0] = tx; m_tm[1] = ty; m_tm[2] = tz;
        m_td[0] = dx; m_td[1] = dy; m_td[2] = dz;
        m_neg = neg;
        model_march();

        origin.x = 7'(ox); origin.y = 7'(oy); origin.z = 7'(oz);
        step_neg = neg;
        tv.x = 16'(tx); tv.y = 16'(ty); tv.z = 16'(tz);
        t_max_init = tv;
        tv.x = 16'(dx); tv.y = 16'(dy); tv.z = 16'(dz);
        t_delta = tv;
        resp_lat = lat;
        got_q.delete();
        addr_changes = 0;
        d0 = done_cnt;

        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        check_eq({tag, ":busy"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        check_eq({tag, ":done"}, done, 1);
        check_eq({tag, ":hit"}, hit, e_hit);
        check_eq({tag, ":pos_x"}, 32'(hit_pos.x), e_pos[0]);
        check_eq({tag, ":pos_y"}, 32'(hit_pos.y), e_pos[1]);
        check_eq({tag, ":pos_z"}, 32'(hit_pos.z), e_pos[2]);
        check_eq({tag, ":block"}, hit_block, e_block);
        check_eq({tag, ":face"}, hit_face, e_face);
        check_eq({tag, ":steps"}, steps, e_steps);
        check_eq({tag, ":valid_to_done"}, cyc_cnt - last_valid_cyc, e_hit ? 1 : 2);
        check_eq({tag, ":n_queries"}, got_q.size(), exp_q.size());
        mism = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] != exp_q[i]) mism++;
        check_eq({tag, ":query_seq"}, mism, 0);
        check_eq({tag, ":addr_stable"}, addr_changes, 0);

        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        check_eq({tag, ":idle_after_done"}, busy, 0);
        check_eq({tag, ":done_once"}, done_cnt - d0, 1);
        check_eq({tag, ":steps_hold"}, steps, e_steps);
        @(posedge clk_in); #1;
    endtask

    function automatic BlockType rand_block();
        case ($urandom_range(1, 4))
            1:       return BLOCK_STONE;
            2:       return BLOCK_DIRT;
            3:       return BLOCK_GRASS;
            default: return BLOCK_WATER;
        endcase
    endfunction

    initial begin
        int bad, d0, ox, oy, oz, nsol;
        int tmr [3];
        int tdr [3];

        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst:busy", busy, 0);
        check_eq("rst:done", done, 0);
        check_eq("rst:hit", hit, 0);
        check_eq("rst:block", hit_block, BLOCK_AIR);
        check_eq("rst:face", hit_face, FACE_NONE);
        check_eq("rst:steps", steps, 0);
        check_eq("rst:read_en", query_read_enable, 0);
        check_eq("rst:addr", 32'(query_addr), 0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        world.delete();
        world[pkey(0, 0, 0)] = BLOCK_STONE;
        run_march("origin_hit", 0, 0, 0, 3'b000, 128, 65535, 65535, 256, 65535, 65535, 2);

        world.delete();
        world[pkey(3, 0, 0)] = BLOCK_STONE;
        run_march("plus_x", 0, 0, 0, 3'b000, 128, 65535, 65535, 256, 65535, 65535, 2);

        world.delete();
        world[pkey(-1, 0, 0)] = BLOCK_DIRT;
        world[pkey(0, -1, 0)] = BLOCK_GRASS;
        run_march("tie", 0, 0, 0, 3'b011, 100, 100, 65535, 200, 200, 65535, 2);

        world.delete();
        run_march("edge", 38, 0, 0, 3'b000, 128, 65535, 65535, 256, 65535, 65535, 2);
        run_march("max_steps", 0, 0, 0, 3'b000, 10, 20, 30, 30, 30, 30, 1);
        run_march("lat0", -40, 39, -40, 3'b010, 5, 5, 5, 7, 3, 65000, 0);

        for (int n = 0; n < 40; n++) begin
            world.delete();
            ox = int'($urandom_range(0, 79)) - 40;
            oy = int'($urandom_range(0, 79)) - 40;
            oz = int'($urandom_range(0, 79)) - 40;
            nsol = $urandom_range(0, 12);
            for (int s = 0; s < nsol; s++) begin
                world[pkey(ox + int'($urandom_range(0, 6)) - 3, oy + int'($urandom_range(0, 6)) - 3,
                           oz + int'($urandom_range(0, 6)) - 3)] = rand_block();
            end
            for (int a = 0; a < 3; a++) begin
                tmr[a] = ($urandom_range(0, 5) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 1000);
                tdr[a] = ($urandom_range(0, 3) == 0) ? $urandom_range(60000, 65535) : $urandom_range(1, 1000);
            end
            run_march($sformatf("rand%0d", n), ox, oy, oz, 3'($urandom_range(0, 7)),
                      tmr[0], tmr[1], tmr[2], tdr[0], tdr[1], tdr[2], $urandom_range(0, 3));
        end

        // Responder withholds valid, then reset lands mid-QUERY.
        world.delete();
        resp_lat = 1000;
        origin.x = 7'(5); origin.y = 7'(-3); origin.z = 7'(7);
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            if (query_read_enable !== 1'b1 || addr_key(query_addr) != pkey(5, -3, 7) || steps !== '0) bad++;
        end
        check_eq("hold:stable", bad, 0);
        origin.x = 7'(1); origin.y = 7'(1); origin.z = 7'(1);
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        check_eq("hold:busy_after_start", busy, 1);
        check_eq("hold:addr_after_start", addr_key(query_addr), pkey(5, -3, 7));
        d0 = done_cnt;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check_eq("rst_mid:busy", busy, 0);
        check_eq("rst_mid:read_en", query_read_enable, 0);
        repeat (5) @(posedge clk_in);
        #1;
        check_eq("rst_mid:no_done", done_cnt - d0, 0);
        check_eq("rst_mid:idle", busy, 0);
        resp_lat = 2;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
